program_loader: RTL and testbench

Write-side companion to the CPU's instruction fetch path. It receives a byte stream over a valid/ready handshake and assembles it into 16-bit instruction words. Each word is written into InstructionMemory at consecutive addresses from 0. While a load is in progress, `cpu_hold` keeps the controller stopped, so a partially loaded program never executes.

---
 rtl/program_loader_pkg.sv | 26 ++
 rtl/program_loader_timeout.sv | 37 +++
 rtl/program_loader.sv | 174 +++++++++++++++++
 tb/tb_program_loader.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/program_loader_pkg.sv
// rtl/program_loader_pkg.sv - shared types and constants for the instruction-memory program loader
package program_loader_pkg;

   typedef enum logic [3:0] {
      IDLE,
      CNT_HI,
      CNT_LO,
      DATA_HI,
      DATA_LO,
      WRITE,
      CHECK,
      DONE,
      ERROR
   } state_t;

   localparam int HEADER_BYTES = 2;
   localparam int WORD_BYTES   = 2;
   localparam int INSTR_WIDTH  = WORD_BYTES * 8;
   localparam int COUNT_WIDTH  = HEADER_BYTES * 8;

   // States in which the loader offers rx_ready and the idle timeout runs.
   function automatic logic is_rx_state(input state_t s);
      return s inside {CNT_HI, CNT_LO, DATA_HI, DATA_LO, CHECK};
   endfunction

endpackage

// File: rtl/program_loader_timeout.sv
// rtl/program_loader_timeout.sv - idle-cycle counter between accepted bytes; expired holds once the limit is reached
module loader_timeout #(
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

   logic [CW-1:0] count_q;
   logic [CW-1:0] count_d;

   assign expired = (count_q >= LIMIT);

   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (enable && !expired) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/program_loader.sv
// rtl/program_loader.sv - assembles a header-prefixed byte stream into 16-bit instruction memory writes
// Optional trailing XOR checksum byte when PROGRAM_LOADER_CHECKSUM_EN is defined.
module program_loader
   import program_loader_pkg::*;
#(
   parameter int ADDR_WIDTH     = 8,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   start,
   input  logic [7:0]             rx_data,
   input  logic                   rx_valid,
   output logic                   rx_ready,
   output logic [ADDR_WIDTH-1:0]  im_address,
   output logic [INSTR_WIDTH-1:0] im_data,
   output logic                   im_wren,
   output logic                   cpu_hold,
   output logic                   busy,
   output logic                   done,
   output logic                   error,
   output logic [ADDR_WIDTH:0]    words_loaded
);

   localparam logic [COUNT_WIDTH:0] DEPTH = (COUNT_WIDTH+1)'(1) << ADDR_WIDTH;

   state_t state_q, state_d;

   logic [COUNT_WIDTH-1:0] count_q;
   logic [INSTR_WIDTH-1:0] data_q;
   logic [ADDR_WIDTH-1:0]  addr_q;
   logic [ADDR_WIDTH:0]    words_q;

   logic rx_ready_q, im_wren_q, cpu_hold_q, busy_q, done_q, error_q;
   logic rx_ready_d, im_wren_d, cpu_hold_d, busy_d, done_d, error_d;

   logic                   accept;
   logic                   start_take;
   logic                   expired;
   logic                   last_word;
   logic [COUNT_WIDTH-1:0] n_next;

   assign accept     = rx_valid && rx_ready_q;
   assign start_take = start && (state_q inside {IDLE, DONE, ERROR});
   assign n_next     = {count_q[COUNT_WIDTH-1:8], rx_data};
   assign last_word  = ((COUNT_WIDTH+1)'(words_q) + 1'b1) == {1'b0, count_q};

   loader_timeout #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timeout (
      .clock  (clock),
      .reset  (reset),
      .clear  (accept || start_take),
      .enable (rx_ready_q),
      .expired(expired)
   );

`ifdef PROGRAM_LOADER_CHECKSUM_EN
   logic [7:0] xor_q;

   always_ff @(posedge clock) begin
      if (reset || start_take) begin
         xor_q <= '0;
      end else if (accept && (state_q inside {DATA_HI, DATA_LO})) begin
         xor_q <= xor_q ^ rx_data;
      end
   end
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (start_take) begin
         state_d = CNT_HI;
      end else if (expired && is_rx_state(state_q)) begin
         state_d = ERROR;
      end else begin
         case (state_q)
            CNT_HI:  if (accept) state_d = CNT_LO;
            CNT_LO: begin
               if (accept) begin
                  if (n_next == '0 || {1'b0, n_next} > DEPTH) state_d = ERROR;
                  else                                        state_d = DATA_HI;
               end
            end
            DATA_HI: if (accept) state_d = DATA_LO;
            DATA_LO: if (accept) state_d = WRITE;
            WRITE: begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
               state_d = last_word ? CHECK : DATA_HI;
`else
               state_d = last_word ? DONE : DATA_HI;
`endif
            end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            CHECK: if (accept) state_d = (rx_data == xor_q) ? DONE : ERROR;
`endif
            DONE:    state_d = IDLE;
            ERROR:   state_d = ERROR;
            IDLE:    state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   // Outputs are decoded from the next state and registered, so they line up with state_q.
   always_comb begin
      rx_ready_d = is_rx_state(state_d);
      im_wren_d  = (state_d == WRITE);
      busy_d     = !(state_d inside {IDLE, DONE, ERROR});
      cpu_hold_d = !(state_d inside {IDLE, DONE});
      done_d     = (state_d == DONE);
      error_d    = (state_d == ERROR);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         rx_ready_q <= 1'b0;
         im_wren_q  <= 1'b0;
         cpu_hold_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         error_q    <= 1'b0;
         count_q    <= '0;
         data_q     <= '0;
         addr_q     <= '0;
         words_q    <= '0;
      end else begin
         rx_ready_q <= rx_ready_d;
         im_wren_q  <= im_wren_d;
         cpu_hold_q <= cpu_hold_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         error_q    <= error_d;

         if (start_take) begin
            addr_q  <= '0;
            words_q <= '0;
         end else if (state_q == WRITE) begin
            words_q <= words_q + 1'b1;
            // Holding the address on the final word keeps a full-depth load from wrapping to 0.
            if (!last_word) addr_q <= addr_q + 1'b1;
         end

         if (accept) begin
            case (state_q)
               CNT_HI:  count_q[COUNT_WIDTH-1:8] <= rx_data;
               CNT_LO:  count_q[7:0]             <= rx_data;
               DATA_HI: data_q[INSTR_WIDTH-1:8]  <= rx_data;
               DATA_LO: data_q[7:0]              <= rx_data;
               default: ;
            endcase
         end
      end
   end

   assign rx_ready     = rx_ready_q;
   assign im_address   = addr_q;
   assign im_data      = data_q;
   assign im_wren      = im_wren_q;
   assign cpu_hold     = cpu_hold_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign error        = error_q;
   assign words_loaded = words_q;

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - scoreboard bench for program_loader; honours PROGRAM_LOADER_CHECKSUM_EN
module tb_program_loader;

   localparam int AW    = 8;
   localparam int TO    = 16;
   localparam int DEPTH = 1 << AW;

   logic          clock    = 1'b0;
   logic          reset    = 1'b1;
   logic          start    = 1'b0;
   logic [7:0]    rx_data  = '0;
   logic          rx_valid = 1'b0;
   logic          rx_ready, im_wren, cpu_hold, busy, done, error;
   logic [AW-1:0] im_address;
   logic [15:0]   im_data;
   logic [AW:0]   words_loaded;

   typedef struct {int addr; logic [15:0] data;} wr_t;
   typedef struct {bit is_done; int words;} out_t;

   wr_t        exp_wr[$];
   out_t       exp_out[$];
   logic [7:0] s[$];
   int         total = 0;
   int         bad   = 0;
   int         n_out = 0;
   logic       err_prev = 1'b0;

   always #5 clock = ~clock;

   program_loader #(
      .ADDR_WIDTH    (AW),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .start       (start),
      .rx_data     (rx_data),
      .rx_valid    (rx_valid),
      .rx_ready    (rx_ready),
      .im_address  (im_address),
      .im_data     (im_data),
      .im_wren     (im_wren),
      .cpu_hold    (cpu_hold),
      .busy        (busy),
      .done        (done),
      .error       (error),
      .words_loaded(words_loaded)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Monitor: pops the scoreboard whenever the DUT writes memory or ends a session.
   always @(negedge clock) begin
      wr_t  w;
      out_t o;
      if (im_wren) begin
         check("write_expected", exp_wr.size() != 0, 1);
         if (exp_wr.size() != 0) begin
            w = exp_wr.pop_front();
            check("wr_addr", im_address, w.addr);
            check("wr_data", im_data, w.data);
         end
      end
      if (done || (error && !err_prev)) begin
         check("end_expected", exp_out.size() != 0, 1);
         if (exp_out.size() != 0) begin
            o = exp_out.pop_front();
            check("end_done", done, o.is_done);
            check("end_error", error, !o.is_done);
            check("end_words_loaded", words_loaded, o.words);
            check("end_cpu_hold", cpu_hold, !o.is_done);
            n_out++;
         end
      end
      err_prev = error;
   end

   // Reference model: derives writes and outcome from the byte stream the bench delivers.
   task automatic model_expect();
      int         n;
      int         words;
      logic [7:0] x;
      out_t       o;
      wr_t        w;
      x = '0;
      o.words = 0;
      o.is_done = 0;
      if (s.size() < 2) begin
         exp_out.push_back(o);
         return;
      end
      n = {s[0], s[1]};
      if (n == 0 || n > DEPTH) begin
         exp_out.push_back(o);
         return;
      end
      words = (s.size() - 2) / 2;
      if (words > n) words = n;
      for (int i = 0; i < words; i++) begin
         w.addr = i;
         w.data = {s[2+2*i], s[3+2*i]};
         exp_wr.push_back(w);
         x = x ^ s[2+2*i] ^ s[3+2*i];
      end
      o.words = words;
      if (words < n) o.is_done = 0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      else if (s.size() < 3 + 2*n) o.is_done = 0;
      else o.is_done = (s[2+2*n] == x);
`else
      else o.is_done = 1;
`endif
      exp_out.push_back(o);
   endtask

   task automatic s_hdr(input int n);
      s.delete();
      s.push_back(n[15:8]);
      s.push_back(n[7:0]);
   endtask

   task automatic s_word(input logic [15:0] w);
      s.push_back(w[15:8]);
      s.push_back(w[7:0]);
   endtask

   task automatic s_chk(input logic [7:0] flip);
      logic [7:0] x;
      x = '0;
      for (int i = 2; i < s.size(); i++) x = x ^ s[i];
      s.push_back(x ^ flip);
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap, output bit ok);
      rx_valid = 1'b0;
      repeat (gap) @(negedge clock);
      rx_data  = b;
      rx_valid = 1'b1;
      ok = 0;
      for (int n = 0; n < 40; n++) begin
         if (rx_ready) begin
            ok = 1;
            break;
         end
         @(negedge clock);
      end
      if (ok) @(negedge clock);
      rx_valid = 1'b0;
      check("byte_accepted", ok, 1);
   endtask

   task automatic pulse_start();
      @(negedge clock);
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
   endtask

   task automatic run_session(input int gapmax, input bit fixed);
      int target;
      bit ok;
      model_expect();
      target = n_out + 1;
      pulse_start();
      foreach (s[i]) begin
         send_byte(s[i], fixed ? gapmax : int'($urandom_range(0, gapmax)), ok);
         if (!ok) break;
      end
      for (int c = 0; c < 300 && n_out < target; c++) @(negedge clock);
      check("session_end_seen", n_out >= target, 1);
      if (n_out < target && exp_out.size() != 0) void'(exp_out.pop_back());
      repeat (3) @(negedge clock);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_rx_ready"}, rx_ready, 0);
      check({tag, "_im_address"}, im_address, 0);
      check({tag, "_im_data"}, im_data, 0);
      check({tag, "_im_wren"}, im_wren, 0);
      check({tag, "_cpu_hold"}, cpu_hold, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_error"}, error, 0);
      check({tag, "_words_loaded"}, words_loaded, 0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      bit ok;
      repeat (3) @(negedge clock);
      check_reset_outputs("reset");
      reset = 1'b0;

      s_hdr(3);
      s_word(16'h8105);
      s_word(16'hC1D0);
      s_word(16'hC0F0);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      s_chk(8'h00);
`endif
      run_session(0, 1);
      check("after_done_cpu_hold", cpu_hold, 0);

      s_hdr(0);
      run_session(0, 1);
      check("zero_hdr_error", error, 1);
      check("zero_hdr_cpu_hold", cpu_hold, 1);
      check("zero_hdr_busy", busy, 0);
      check("zero_hdr_rx_ready", rx_ready, 0);

      s_hdr(16'h0101);
      run_session(0, 1);

      s_hdr(DEPTH);
      for (int i = 0; i < DEPTH; i++) s_word(16'($urandom));
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      s_chk(8'h00);
`endif
      run_session(0, 1);

      s_hdr(4);
      for (int i = 0; i < 4; i++) s_word(16'($urandom));
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      s_chk(8'h00);
`endif
      run_session(5, 1);
      check("stall5_error_clear", error, 0);

      s_hdr(3);
      s.push_back(8'h81);
      run_session(0, 1);
      check("timeout_words_loaded", words_loaded, 0);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
      s_hdr(2);
      s_word(16'h1234);
      s_word(16'h5678);
      s.push_back(8'h08);
      run_session(0, 1);
      s_hdr(2);
      s_word(16'h1234);
      s_word(16'h5678);
      s.push_back(8'h09);
      run_session(0, 1);
      check("bad_checksum_error", error, 1);
`endif

      for (int k = 0; k < 4; k++) begin
         s_hdr(int'($urandom_range(1, 12)));
         for (int i = 0; i < {s[0], s[1]}; i++) s_word(16'($urandom));
`ifdef PROGRAM_LOADER_CHECKSUM_EN
         s_chk(($urandom_range(0, 2) == 0) ? 8'h5A : 8'h00);
`endif
         run_session(3, 0);
      end

      // Reset while the second word's low byte is pending.
      s_hdr(3);
      s_word(16'hAABB);
      s_word(16'hCCDD);
      exp_wr.push_back('{0, 16'hAABB});
      pulse_start();
      for (int i = 0; i < 5; i++) send_byte(s[i], 0, ok);
      reset = 1'b1;
      @(negedge clock);
      check_reset_outputs("midreset");
      reset = 1'b0;
      check("midreset_writes_drained", exp_wr.size(), 0);

      s_hdr(3);
      s_word(16'h0F1E);
      s_word(16'h2D3C);
      s_word(16'h4B5A);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      s_chk(8'h00);
`endif
      run_session(1, 0);

      check("final_write_queue_empty", exp_wr.size(), 0);
      check("final_end_queue_empty", exp_out.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
